// File: rtl/p4_router_ingress_dwrr_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p4_router_ingress_dwrr_sched_if                                 |
// | Brief    : Port-status / grant bundle between the ingress buffer, the      |
// |            DWRR scheduler and the buffer read sequencer.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface p4_router_ingress_dwrr_sched_if #(
   parameter int NUM_PORTS      = 4,
   parameter int BYTE_LEN_WIDTH = 11,
   parameter int QUANTUM_WIDTH  = 12
);
   localparam int PORT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0]                pkt_avail;
   logic [NUM_PORTS*BYTE_LEN_WIDTH-1:0] head_byte_length;
   logic [NUM_PORTS*QUANTUM_WIDTH-1:0]  quantum;
   logic                                grant_valid;
   logic [PORT_WIDTH-1:0]               grant_port;
   logic [BYTE_LEN_WIDTH-1:0]           grant_byte_length;
   logic                                grant_ready;
   logic                                pkt_done;
   logic                                sched_busy;

   // Scheduler side: consumes port status, offers grants.
   modport master (
      input  pkt_avail, head_byte_length, quantum, grant_ready, pkt_done,
      output grant_valid, grant_port, grant_byte_length, sched_busy
   );

   // Buffer / sequencer side.
   modport slave (
      output pkt_avail, head_byte_length, quantum, grant_ready, pkt_done,
      input  grant_valid, grant_port, grant_byte_length, sched_busy
   );
endinterface
`default_nettype wire

// File: rtl/p4_router_ingress_dwrr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p4_router_ingress_dwrr_sched                                    |
// | Brief    : Deficit-weighted round-robin packet scheduler for the ingress   |
// |            buffer read side. Grants one port's head packet at a time.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module p4_router_ingress_dwrr_sched #(
   parameter int NUM_PORTS      = 4,
   parameter int BYTE_LEN_WIDTH = 11,
   parameter int QUANTUM_WIDTH  = 12,
   parameter int DEFICIT_WIDTH  = 14
) (
   input  wire logic                      clk,
   input  wire logic                      sreset,
   p4_router_ingress_dwrr_sched_if.master bus
);
   localparam int                       PORT_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PORT_WIDTH-1:0]    LAST_PORT   = PORT_WIDTH'(NUM_PORTS - 1);
   localparam logic [DEFICIT_WIDTH-1:0] DEFICIT_MAX = '1;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t                    state;
   logic [PORT_WIDTH-1:0]     cur_port;
   logic                      credited;
   logic [DEFICIT_WIDTH-1:0]  deficit [NUM_PORTS];

   logic [BYTE_LEN_WIDTH-1:0] len_slice     [NUM_PORTS];
   logic [QUANTUM_WIDTH-1:0]  quantum_slice [NUM_PORTS];

   // Unpack the flat per-port buses into arrays indexed by port.
   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slice
         assign len_slice[p]     = bus.head_byte_length[p*BYTE_LEN_WIDTH +: BYTE_LEN_WIDTH];
         assign quantum_slice[p] = bus.quantum[p*QUANTUM_WIDTH +: QUANTUM_WIDTH];
      end
   endgenerate

   logic                      cur_avail;
   logic [BYTE_LEN_WIDTH-1:0] cur_len;
   logic [QUANTUM_WIDTH-1:0]  cur_quantum;
   logic [DEFICIT_WIDTH-1:0]  cur_deficit;
   logic [DEFICIT_WIDTH:0]    credit_sum;
   logic [DEFICIT_WIDTH-1:0]  credit_sat;
   logic                      deficit_ok;
   logic [PORT_WIDTH-1:0]     next_port;

   assign cur_avail   = bus.pkt_avail[cur_port];
   assign cur_len     = len_slice[cur_port];
   assign cur_quantum = quantum_slice[cur_port];
   assign cur_deficit = deficit[cur_port];

   // Quantum credit saturates rather than wrapping so a long-starved port never loses credit.
   assign credit_sum  = {1'b0, cur_deficit} + (DEFICIT_WIDTH+1)'(cur_quantum);
   assign credit_sat  = credit_sum[DEFICIT_WIDTH] ? DEFICIT_MAX : credit_sum[DEFICIT_WIDTH-1:0];
   assign deficit_ok  = cur_deficit >= DEFICIT_WIDTH'(cur_len);
   assign next_port   = (cur_port == LAST_PORT) ? '0 : cur_port + 1'b1;

   // Scheduler FSM: scan/credit ports, offer grant, wait for packet completion.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state                 <= SCAN;
         cur_port              <= '0;
         credited              <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            deficit[p] <= '0;
         end
         bus.grant_valid       <= 1'b0;
         bus.grant_port        <= '0;
         bus.grant_byte_length <= '0;
         bus.sched_busy        <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (!cur_avail || (cur_quantum == '0)) begin
                  // Idle or disabled ports carry no credit forward.
                  deficit[cur_port] <= '0;
                  credited          <= 1'b0;
                  cur_port          <= next_port;
               end else if (!credited) begin
                  deficit[cur_port] <= credit_sat;
                  credited          <= 1'b1;
               end else if (deficit_ok) begin
                  bus.grant_port        <= cur_port;
                  bus.grant_byte_length <= cur_len;
                  bus.grant_valid       <= 1'b1;
                  bus.sched_busy        <= 1'b1;
                  state                 <= GRANT;
               end else begin
                  credited <= 1'b0;
                  cur_port <= next_port;
               end
            end
            GRANT: begin
               // Deficit was checked against this very length, so no underflow.
               if (bus.grant_ready) begin
                  deficit[cur_port] <= cur_deficit - DEFICIT_WIDTH'(bus.grant_byte_length);
                  bus.grant_valid   <= 1'b0;
                  state             <= BUSY;
               end
            end
            BUSY: begin
               // Return to the same port already credited: it may send more this turn.
               if (bus.pkt_done) begin
                  credited       <= 1'b1;
                  bus.sched_busy <= 1'b0;
                  state          <= SCAN;
               end
            end
            default: begin
               state <= SCAN;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_p4_router_ingress_dwrr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_p4_router_ingress_dwrr_sched                                 |
// | Brief    : Scoreboard bench for the DWRR ingress scheduler: a queue-based  |
// |            DWRR model predicts the grant sequence, a monitor compares.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_p4_router_ingress_dwrr_sched;
   localparam int NP      = 4;
   localparam int BLW     = 11;
   localparam int QW      = 12;
   localparam int DW      = 14;
   localparam int DEF_MAX = (1 << DW) - 1;

   typedef struct {
      int port;
      int len;
   } grant_t;

   logic clk = 1'b0;
   logic sreset;

   always #5 clk = ~clk;

   p4_router_ingress_dwrr_sched_if #(.NUM_PORTS(NP), .BYTE_LEN_WIDTH(BLW), .QUANTUM_WIDTH(QW)) bus ();

   p4_router_ingress_dwrr_sched #(
      .NUM_PORTS(NP), .BYTE_LEN_WIDTH(BLW), .QUANTUM_WIDTH(QW), .DEFICIT_WIDTH(DW)
   ) dut (
      .clk    (clk),
      .sreset (sreset),
      .bus    (bus)
   );

   grant_t        exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            pktq[NP][$];
   int            quanta[NP];
   logic [NP-1:0] avail_mask;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present each port's queue head, availability and quantum on the bus.
   task automatic drive_inputs();
      for (int p = 0; p < NP; p++) begin
         bus.pkt_avail[p]                  = (pktq[p].size() > 0) && avail_mask[p];
         bus.head_byte_length[p*BLW +: BLW] = (pktq[p].size() > 0) ? BLW'(pktq[p][0]) : '0;
         bus.quantum[p*QW +: QW]            = QW'(quanta[p]);
      end
   endtask

   // Reference DWRR: visit ports in order; empty/disabled ports lose credit,
   // others gain a quantum and send head packets while the deficit covers them.
   task automatic build_expected(output int n);
      int     mq[NP][$];
      int     def[NP];
      int     remaining;
      int     p;
      grant_t g;
      remaining = 0;
      p         = 0;
      n         = 0;
      for (int i = 0; i < NP; i++) begin
         mq[i]  = pktq[i];
         def[i] = 0;
         if (quanta[i] > 0) remaining += pktq[i].size();
      end
      while (remaining > 0) begin
         if (mq[p].size() == 0 || quanta[p] == 0) begin
            def[p] = 0;
         end else begin
            def[p] = (def[p] + quanta[p] > DEF_MAX) ? DEF_MAX : def[p] + quanta[p];
            while (mq[p].size() > 0 && def[p] >= mq[p][0]) begin
               g.port = p;
               g.len  = mq[p][0];
               exp_q.push_back(g);
               def[p] -= mq[p][0];
               void'(mq[p].pop_front());
               remaining--;
               n++;
            end
         end
         p = (p + 1) % NP;
      end
   endtask

   // Monitor: every new grant must match the next predicted one and stay put until accepted.
   initial begin
      logic   prev_valid;
      bit     have_exp;
      grant_t cur_exp;
      prev_valid = 1'b0;
      have_exp   = 1'b0;
      forever begin
         @(negedge clk);
         if (sreset) begin
            prev_valid = 1'b0;
            have_exp   = 1'b0;
         end else begin
            if (bus.grant_valid && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  have_exp = 1'b0;
                  $display("FAIL unexpected_grant: got port %0d len %0d, expected no grant",
                           bus.grant_port, bus.grant_byte_length);
               end else begin
                  cur_exp  = exp_q.pop_front();
                  have_exp = 1'b1;
                  check("grant_port", int'(bus.grant_port), cur_exp.port);
                  check("grant_byte_length", int'(bus.grant_byte_length), cur_exp.len);
                  check("busy_with_grant", int'(bus.sched_busy), 1);
               end
            end else if (bus.grant_valid && bus.grant_ready && have_exp) begin
               check("held_grant_port", int'(bus.grant_port), cur_exp.port);
               check("held_grant_byte_length", int'(bus.grant_byte_length), cur_exp.len);
            end
            prev_valid = bus.grant_valid;
         end
      end
   end

   // Sequencer: wait for a grant, stall it while wiggling the port's avail, accept, read.
   task automatic serve_one(input bit chk_lat, input int exp_lat, output bit ok);
      int w;
      int gp;
      int hold;
      w = 0;
      while (!bus.grant_valid && w < 3000) begin
         @(posedge clk); #1;
         w++;
      end
      if (!bus.grant_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL grant_timeout: got no grant after %0d cycles, expected a grant", w);
         ok = 1'b0;
         return;
      end
      if (chk_lat) check("grant_latency", w, exp_lat);
      gp   = int'(bus.grant_port);
      hold = $urandom_range(0, 10);
      for (int i = 0; i < hold; i++) begin
         avail_mask[gp] = 1'($urandom_range(0, 1));
         drive_inputs();
         @(posedge clk); #1;
      end
      avail_mask = '1;
      drive_inputs();
      bus.grant_ready = 1'b1;
      @(posedge clk); #1;
      bus.grant_ready = 1'b0;
      if (pktq[gp].size() > 0) void'(pktq[gp].pop_front());
      drive_inputs();
      check("valid_after_handshake", int'(bus.grant_valid), 0);
      check("busy_after_handshake", int'(bus.sched_busy), 1);
      repeat ($urandom_range(0, 5)) begin
         @(posedge clk); #1;
      end
      ok = 1'b1;
   endtask

   task automatic pulse_done();
      bus.pkt_done = 1'b1;
      @(posedge clk); #1;
      bus.pkt_done = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_grant_valid", int'(bus.grant_valid), 0);
      check("rst_sched_busy", int'(bus.sched_busy), 0);
      check("rst_grant_port", int'(bus.grant_port), 0);
      check("rst_grant_byte_length", int'(bus.grant_byte_length), 0);
   endtask

   // Reset, predict the whole phase, then release reset. Release is at posedge+1.
   task automatic start_phase(output int n);
      sreset          = 1'b1;
      bus.grant_ready = 1'b0;
      bus.pkt_done    = 1'b0;
      avail_mask      = '1;
      drive_inputs();
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_reset_outputs();
      exp_q.delete();
      build_expected(n);
      sreset = 1'b0;
   endtask

   // Serve n grants; with chk_lat, startup latency is 2 edges after release and
   // the pkt_done-to-grant latency is 1 edge after the pkt_done edge (2 cycles).
   task automatic run_grants(input int n, input bit chk_lat);
      bit ok;
      for (int k = 0; k < n; k++) begin
         serve_one(chk_lat, (k == 0) ? 2 : 1, ok);
         if (!ok) break;
         pulse_done();
      end
      repeat (40) begin
         @(posedge clk); #1;
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic clear_ports();
      for (int p = 0; p < NP; p++) begin
         pktq[p].delete();
         quanta[p] = 0;
      end
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit ok;
      sreset          = 1'b1;
      bus.grant_ready = 1'b0;
      bus.pkt_done    = 1'b0;
      avail_mask      = '1;
      clear_ports();
      drive_inputs();

      // Single port, small packets: latency and back-to-back behaviour.
      clear_ports();
      quanta[0] = 1500;
      repeat (5) pktq[0].push_back(64);
      start_phase(n);
      run_grants(n, 1'b1);

      // Large vs small packets at equal quanta: 1 x 1500B then 23 x 64B per round.
      clear_ports();
      quanta[0] = 1500;
      quanta[1] = 1500;
      repeat (3) pktq[0].push_back(1500);
      repeat (69) pktq[1].push_back(64);
      start_phase(n);
      run_grants(n, 1'b0);

      // Quantum below packet length: credit builds over several visits.
      clear_ports();
      quanta[2] = 500;
      repeat (2) pktq[2].push_back(1500);
      start_phase(n);
      run_grants(n, 1'b0);

      // Disabled port with traffic is never granted; others proceed.
      clear_ports();
      quanta[0] = 300;
      quanta[1] = 0;
      quanta[3] = 1000;
      repeat (3) pktq[1].push_back(100);
      repeat (2) pktq[0].push_back(500);
      repeat (3) pktq[3].push_back($urandom_range(1, 2047));
      start_phase(n);
      run_grants(n, 1'b0);

      // Reset while a packet is being read, with stray pkt_done during and after reset.
      clear_ports();
      quanta[0] = 1000;
      quanta[2] = 700;
      repeat (3) pktq[0].push_back(600);
      repeat (2) pktq[2].push_back(300);
      start_phase(n);
      serve_one(1'b0, 0, ok);
      sreset = 1'b1;
      @(posedge clk); #1;
      bus.pkt_done = 1'b1;
      @(posedge clk); #1;
      bus.pkt_done = 1'b0;
      check_reset_outputs();
      exp_q.delete();
      build_expected(n);
      sreset = 1'b0;
      pulse_done();
      run_grants(n, 1'b0);

      // Randomised traffic and quanta.
      for (int ph = 0; ph < 12; ph++) begin
         clear_ports();
         for (int p = 0; p < NP; p++) begin
            quanta[p] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(200, 4095));
            repeat ($urandom_range(0, 6)) pktq[p].push_back(int'($urandom_range(1, 2047)));
         end
         start_phase(n);
         run_grants(n, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
